exe_stage: RTL



---
 rtl/exe_stage.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// ============================================================================
// exe_stage -- execute stage of the 5-stage in-order MIPS pipeline.
//
// Latches the decode bus over the valid/allowin handshake, computes the ALU
// result, runs an iterative 32-cycle shift-and-add multiplier for MUL, issues
// the data SRAM request for loads/stores in the handoff cycle and forwards
// pc, load flag, writeback info and result to the memory stage.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   ms_allowin       memory stage can accept this cycle
//   es_allowin       execute stage can accept this cycle
//   ds_to_es_valid   decode holds a valid instruction
//   ds_to_es_bus     {pc, alu_op[3:0], load_op, store_op, rf_we, rf_addr[4:0],
//                     src1, src2, store_data}, MSB first
//   es_to_ms_valid   result valid toward memory stage
//   es_to_ms_bus     {pc, load_op, rf_we, rf_addr[4:0], alu_result}, MSB first
//   data_sram_en     data SRAM access enable (handoff cycle only)
//   data_sram_wen    byte write enables (all four for a store)
//   data_sram_addr   byte address (= alu_result)
//   data_sram_wdata  store data
//
// Optional feature, macro EXE_FWD_BUS_EN:
//   adds es_fwd_bus[38:0] = {valid & rf_we, valid & load_op, rf_addr,
//   alu_result} for decode-stage bypass and load-use stall detection; all
//   zero while the stage is empty.
// ============================================================================
module exe_stage #(
   parameter int DS_TO_ES_BUS_WD = 140,
   parameter int ES_TO_MS_BUS_WD = 71
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_wen,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
`ifdef EXE_FWD_BUS_EN
   ,
   output logic [38:0]                es_fwd_bus
`endif
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_LUI  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // -------------------------------------------------------------------------
   // Pipeline register and handshake
   // -------------------------------------------------------------------------
   logic                       es_valid;
   logic [DS_TO_ES_BUS_WD-1:0] es_bus;
   logic                       es_ready_go;
   logic                       fire;

   logic [31:0] pc;
   logic [3:0]  alu_op;
   logic        load_op;
   logic        store_op;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] store_data;

   assign {pc, alu_op, load_op, store_op, rf_we, rf_addr,
           src1, src2, store_data} = es_bus;

   assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
   assign es_to_ms_valid = es_valid & es_ready_go;
   assign fire           = es_valid & es_ready_go & ms_allowin;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         es_valid <= 1'b0;
      end else if (es_allowin) begin
         es_valid <= ds_to_es_valid;
      end
   end

   // The bus register is cleared on reset so the output bus and SRAM address
   // read as zero while the stage is empty after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         es_bus <= '0;
      end else if (es_allowin && ds_to_es_valid) begin
         es_bus <= ds_to_es_bus;
      end
   end

   // -------------------------------------------------------------------------
   // Iterative multiplier: one shift-and-add step per BUSY cycle
   // -------------------------------------------------------------------------
   mul_state_t  mul_state;
   mul_state_t  mul_state_next;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [4:0]  cnt;
   logic        is_mul;

   assign is_mul = (alu_op == OP_MUL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_state <= MUL_IDLE;
      end else begin
         mul_state <= mul_state_next;
      end
   end

   // NOTE: every signal written in a combinational block gets a default first,
   // so no path through the case statement can infer a latch.
   always_comb begin
      mul_state_next = mul_state;
      case (mul_state)
         MUL_IDLE: if (es_valid && is_mul) mul_state_next = MUL_BUSY;
         MUL_BUSY: if (cnt == 5'd31)       mul_state_next = MUL_DONE;
         MUL_DONE: if (ms_allowin)         mul_state_next = MUL_IDLE;
         default:                          mul_state_next = MUL_IDLE;
      endcase
   end

   // A MUL holds the stage until its product is ready; all else is one cycle.
   always_comb begin
      es_ready_go = 1'b1;
      if (is_mul) begin
         es_ready_go = (mul_state == MUL_DONE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         case (mul_state)
            MUL_IDLE: begin
               if (es_valid && is_mul) begin
                  acc    <= '0;
                  mcand  <= src1;
                  mplier <= src2;
                  cnt    <= '0;
               end
            end
            MUL_BUSY: begin
               acc    <= acc + (mplier[0] ? mcand : 32'd0);
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // ALU
   // -------------------------------------------------------------------------
   logic [31:0] alu_result;
   logic [4:0]  shamt;

   assign shamt = src1[4:0];

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         OP_ADD:  alu_result = src1 + src2;
         OP_SUB:  alu_result = src1 - src2;
         OP_AND:  alu_result = src1 & src2;
         OP_OR:   alu_result = src1 | src2;
         OP_XOR:  alu_result = src1 ^ src2;
         OP_NOR:  alu_result = ~(src1 | src2);
         OP_SLT:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
         OP_SLTU: alu_result = {31'd0, src1 < src2};
         OP_SLL:  alu_result = src2 << shamt;
         OP_SRL:  alu_result = src2 >> shamt;
         OP_SRA:  alu_result = $signed(src2) >>> shamt;
         OP_LUI:  alu_result = {src2[15:0], 16'h0000};
         OP_MUL:  alu_result = acc;
         default: alu_result = 32'd0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Data SRAM request and output bus
   // -------------------------------------------------------------------------
   // Gating on fire issues exactly one request per memory instruction, even
   // when the memory stage stalls it for several cycles.
   assign data_sram_en    = fire & (load_op | store_op);
   assign data_sram_wen   = {4{fire & store_op}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = store_data;

   assign es_to_ms_bus = {pc, load_op, rf_we, rf_addr, alu_result};

`ifdef EXE_FWD_BUS_EN
   assign es_fwd_bus = es_valid ? {rf_we, load_op, rf_addr, alu_result} : 39'd0;
`endif

endmodule
